lpc_rf_arbiter: RTL and testbench

Access controller for the 32-bit x 11-entry coefficient register file (one-hot write select, one-hot read select, combinational read).
- Shares the file between a producer (write port, e.g. the autocorrelation unit) and a consumer (read port, e.g. the Levinson-Durbin stage).
- Uses valid/ready handshakes, round-robin arbitration and a per-entry written scoreboard.
- Reads of entries not yet written in the current frame stall until they are written.

---
 rtl/lpc_rf_pkg.sv | 38 +++
 rtl/lpc_rr_arb2.sv | 52 +++++
 rtl/lpc_rf_arbiter.sv | 147 ++++++++++++++
 tb/tb_lpc_rf_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_rf_pkg.sv
// rtl/lpc_rf_pkg.sv - shared constants, types and helpers for the coefficient register-file arbiter
// Purpose: sizes of the 11 x 32-bit coefficient file, FSM state and grant encodings,
//          and the binary-index to one-hot select conversion used by both file ports.
package lpc_rf_pkg;

   localparam int N_ENTRY = 11;
   localparam int DW      = 32;
   localparam int IW      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } state_e;

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_e;

   // Out-of-range indices produce an all-zero select so the file is never touched.
   function automatic logic [N_ENTRY-1:0] idx2onehot(input logic [IW-1:0] idx);
      logic [N_ENTRY-1:0] oh;
      oh = '0;
      for (int i = 0; i < N_ENTRY; i++) begin
         if (idx == IW'(i)) begin
            oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

   function automatic logic idx_oob(input logic [IW-1:0] idx);
      return (idx >= IW'(N_ENTRY));
   endfunction

endpackage

// File: rtl/lpc_rr_arb2.sv
// rtl/lpc_rr_arb2.sv - two-requester round-robin arbiter (write vs read)
// Purpose: combinational grant between the write and read requesters.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   en_i                - arbitration allowed this cycle (controller idle)
//   req_wr_i, req_rd_i  - eligible requests
//   gnt_wr_o, gnt_rd_o  - at most one high
module lpc_rr_arb2
   import lpc_rf_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic req_wr_i,
   input  logic req_rd_i,
   output logic gnt_wr_o,
   output logic gnt_rd_o
);

   grant_e last_grant_q, last_grant_d;

   // last_grant only moves on contention; an uncontested grant leaves the
   // fairness history untouched.
   always_comb begin
      gnt_wr_o     = 1'b0;
      gnt_rd_o     = 1'b0;
      last_grant_d = last_grant_q;
      if (en_i) begin
         if (req_wr_i && req_rd_i) begin
            if (last_grant_q == GRANT_RD) begin
               gnt_wr_o     = 1'b1;
               last_grant_d = GRANT_WR;
            end else begin
               gnt_rd_o     = 1'b1;
               last_grant_d = GRANT_RD;
            end
         end else begin
            gnt_wr_o = req_wr_i;
            gnt_rd_o = req_rd_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= GRANT_RD;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/lpc_rf_arbiter.sv
// rtl/lpc_rf_arbiter.sv - access controller sharing the coefficient register file between producer and consumer
// Purpose: arbitrates producer writes and consumer reads onto the one-hot register-file
//          ports, tracking which entries have been written in the current frame.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_idx/wr_data    - producer write request
//   rd_valid/rd_ready/rd_idx            - consumer read request
//   rd_resp_valid/rd_resp_ready/rd_resp_data - read response
//   frame_clr, frame_full               - scoreboard clear / all-written flag
//   err_idx                             - pulse after an out-of-range index is accepted
//   rf_wsel, rf_din, rf_rsel, rf_dout   - register-file interface
module lpc_rf_arbiter
   import lpc_rf_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [IW-1:0]      wr_idx,
   input  logic [DW-1:0]      wr_data,
   input  logic               rd_valid,
   output logic               rd_ready,
   input  logic [IW-1:0]      rd_idx,
   output logic               rd_resp_valid,
   input  logic               rd_resp_ready,
   output logic [DW-1:0]      rd_resp_data,
   input  logic               frame_clr,
   output logic               frame_full,
   output logic               err_idx,
   output logic [N_ENTRY-1:0] rf_wsel,
   output logic [DW-1:0]      rf_din,
   output logic [N_ENTRY-1:0] rf_rsel,
   input  logic [DW-1:0]      rf_dout
);

   state_e             state_q, state_d;
   logic [N_ENTRY-1:0] sb_q, sb_d;
   logic [N_ENTRY-1:0] wsel_q, wsel_d;
   logic [N_ENTRY-1:0] rsel_q, rsel_d;
   logic [DW-1:0]      din_q, din_d;
   logic [DW-1:0]      resp_data_q, resp_data_d;
   logic               rd_oob_q, rd_oob_d;
   logic               err_q, err_d;
   logic               full_q, full_d;

   logic               is_idle;
   logic               wr_elig, rd_elig;
   logic               gnt_wr, gnt_rd;

   assign is_idle = (state_q == IDLE);
   assign wr_elig = wr_valid;
   // Out-of-range reads never stall; they complete with zero data.
   assign rd_elig = rd_valid & (idx_oob(rd_idx) | (|(sb_q & idx2onehot(rd_idx))));

   lpc_rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .en_i     (is_idle),
      .req_wr_i (wr_elig),
      .req_rd_i (rd_elig),
      .gnt_wr_o (gnt_wr),
      .gnt_rd_o (gnt_rd)
   );

   always_comb begin
      state_d     = state_q;
      sb_d        = sb_q;
      wsel_d      = '0;
      rsel_d      = '0;
      din_d       = din_q;
      resp_data_d = resp_data_q;
      rd_oob_d    = rd_oob_q;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (gnt_wr) begin
               state_d = WR;
               wsel_d  = idx2onehot(wr_idx);
               din_d   = wr_data;
               err_d   = idx_oob(wr_idx);
            end else if (gnt_rd) begin
               state_d  = RD;
               rsel_d   = idx2onehot(rd_idx);
               rd_oob_d = idx_oob(rd_idx);
               err_d    = idx_oob(rd_idx);
            end
         end
         WR: begin
            // wsel_q is zero for an out-of-range index, so the scoreboard is untouched.
            sb_d    = sb_q | wsel_q;
            state_d = IDLE;
         end
         RD: begin
            resp_data_d = rd_oob_q ? '0 : rf_dout;
            state_d     = RESP;
         end
         RESP: begin
            if (rd_resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A clear coinciding with a write wins over that write's scoreboard set.
      if (frame_clr) begin
         sb_d = '0;
      end
      full_d = &sb_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sb_q        <= '0;
         wsel_q      <= '0;
         rsel_q      <= '0;
         din_q       <= '0;
         resp_data_q <= '0;
         rd_oob_q    <= 1'b0;
         err_q       <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sb_q        <= sb_d;
         wsel_q      <= wsel_d;
         rsel_q      <= rsel_d;
         din_q       <= din_d;
         resp_data_q <= resp_data_d;
         rd_oob_q    <= rd_oob_d;
         err_q       <= err_d;
         full_q      <= full_d;
      end
   end

   assign wr_ready      = gnt_wr;
   assign rd_ready      = gnt_rd;
   assign rd_resp_valid = (state_q == RESP);
   assign rd_resp_data  = resp_data_q;
   assign frame_full    = full_q;
   assign err_idx       = err_q;
   assign rf_wsel       = wsel_q;
   assign rf_din        = din_q;
   assign rf_rsel       = rsel_q;

endmodule

// File: tb/tb_lpc_rf_arbiter.sv
// tb/tb_lpc_rf_arbiter.sv - directed self-checking bench for lpc_rf_arbiter
module tb_lpc_rf_arbiter;
   import lpc_rf_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               wr_valid, wr_ready;
   logic [IW-1:0]      wr_idx;
   logic [DW-1:0]      wr_data;
   logic               rd_valid, rd_ready;
   logic [IW-1:0]      rd_idx;
   logic               rd_resp_valid, rd_resp_ready;
   logic [DW-1:0]      rd_resp_data;
   logic               frame_clr, frame_full, err_idx;
   logic [N_ENTRY-1:0] rf_wsel, rf_rsel;
   logic [DW-1:0]      rf_din, rf_dout;

   always #5 clk = ~clk;

   lpc_rf_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_idx        (wr_idx),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_idx        (rd_idx),
      .rd_resp_valid (rd_resp_valid),
      .rd_resp_ready (rd_resp_ready),
      .rd_resp_data  (rd_resp_data),
      .frame_clr     (frame_clr),
      .frame_full    (frame_full),
      .err_idx       (err_idx),
      .rf_wsel       (rf_wsel),
      .rf_din        (rf_din),
      .rf_rsel       (rf_rsel),
      .rf_dout       (rf_dout)
   );

   // Register-file model driven only by the DUT select lines.
   logic [DW-1:0] rf_mem [N_ENTRY];
   always @(posedge clk) begin
      for (int i = 0; i < N_ENTRY; i++) begin
         if (rf_wsel[i]) rf_mem[i] <= rf_din;
      end
   end
   always_comb begin
      rf_dout = '0;
      for (int i = 0; i < N_ENTRY; i++) begin
         if (rf_rsel[i]) rf_dout = rf_dout | rf_mem[i];
      end
   end

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_mem [N_ENTRY];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic pop_chk(input string tag);
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_nonempty"}, 64'(exp_q.size()), 64'd1);
      end else begin
         chk(tag, 64'(rd_resp_data), 64'(exp_q.pop_front()));
      end
   endtask

   // Starts and ends at posedge+1; ends in the WR cycle of the accepted write.
   task automatic do_write(input logic [IW-1:0] idx, input logic [DW-1:0] data);
      logic got;
      got      = 1'b0;
      wr_idx   = idx;
      wr_data  = data;
      wr_valid = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         smp();
         if (wr_ready) begin
            got = 1'b1;
            if (idx < IW'(N_ENTRY)) exp_mem[idx] = data;
         end
         cyc();
      end
      wr_valid = 1'b0;
      chk("wr_accept", 64'(got), 64'd1);
   endtask

   // Starts and ends at posedge+1; ends in the RD cycle of the accepted read.
   task automatic do_read(input logic [IW-1:0] idx, input logic resp_rdy);
      logic got;
      got           = 1'b0;
      rd_idx        = idx;
      rd_resp_ready = resp_rdy;
      rd_valid      = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         smp();
         if (rd_ready) begin
            got = 1'b1;
            exp_q.push_back((idx < IW'(N_ENTRY)) ? exp_mem[idx] : '0);
         end
         cyc();
      end
      rd_valid = 1'b0;
      chk("rd_accept", 64'(got), 64'd1);
   endtask

   initial begin
      logic [3:0] gseq;
      int         ngrant;
      logic       both;

      for (int i = 0; i < N_ENTRY; i++) exp_mem[i] = '0;
      reset = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_data = '0;
      rd_valid = 1'b0; rd_idx = '0; rd_resp_ready = 1'b0; frame_clr = 1'b0;
      repeat (3) cyc();
      smp();
      chk("rst_resp_valid", 64'(rd_resp_valid), 64'd0);
      chk("rst_resp_data", 64'(rd_resp_data), 64'd0);
      chk("rst_wsel", 64'(rf_wsel), 64'd0);
      chk("rst_rsel", 64'(rf_rsel), 64'd0);
      chk("rst_din", 64'(rf_din), 64'd0);
      chk("rst_err", 64'(err_idx), 64'd0);
      chk("rst_full", 64'(frame_full), 64'd0);
      cyc();
      reset = 1'b0;

      // Write then read entry 3.
      do_write(4'd3, 32'hDEADBEEF);
      smp();
      chk("t1_wsel", 64'(rf_wsel), 64'h008);
      chk("t1_din", 64'(rf_din), 64'hDEADBEEF);
      cyc();
      smp();
      chk("t1_wsel_off", 64'(rf_wsel), 64'h000);
      cyc();
      do_read(4'd3, 1'b1);
      smp();
      chk("t1_rsel", 64'(rf_rsel), 64'h008);
      chk("t1_valid_n1", 64'(rd_resp_valid), 64'd0);
      cyc();
      smp();
      chk("t1_valid_n2", 64'(rd_resp_valid), 64'd1);
      pop_chk("t1_data");
      cyc();

      // Read of unwritten entry 5 stalls until its write lands.
      rd_idx = 4'd5; rd_valid = 1'b1; rd_resp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("t2_stall", 64'(rd_ready), 64'd0);
         cyc();
      end
      wr_idx = 4'd5; wr_data = 32'h12345678; wr_valid = 1'b1;
      smp();
      chk("t2_wr_ready", 64'(wr_ready), 64'd1);
      chk("t2_rd_blocked", 64'(rd_ready), 64'd0);
      exp_mem[5] = 32'h12345678;
      cyc();
      wr_valid = 1'b0;
      smp();
      chk("t2_rd_in_wr", 64'(rd_ready), 64'd0);
      cyc();
      smp();
      chk("t2_rd_ready", 64'(rd_ready), 64'd1);
      if (rd_ready) exp_q.push_back(exp_mem[5]);
      cyc();
      rd_valid = 1'b0;
      smp();
      cyc();
      smp();
      chk("t2_valid", 64'(rd_resp_valid), 64'd1);
      pop_chk("t2_data");
      cyc();

      // Continuous contention: W, R, W, R.
      do_write(4'd0, 32'h000000AA);
      wr_idx = 4'd1; wr_data = 32'h00000011; wr_valid = 1'b1;
      rd_idx = 4'd0; rd_valid = 1'b1; rd_resp_ready = 1'b1;
      gseq = '0; ngrant = 0; both = 1'b0;
      for (int k = 0; k < 30 && ngrant < 4; k++) begin
         smp();
         if (wr_ready && rd_ready) both = 1'b1;
         if (wr_ready) begin
            gseq = {gseq[2:0], 1'b0}; ngrant++; exp_mem[1] = wr_data;
         end else if (rd_ready) begin
            gseq = {gseq[2:0], 1'b1}; ngrant++; exp_q.push_back(exp_mem[0]);
         end
         if (rd_resp_valid) pop_chk("t3_data");
         cyc();
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         smp();
         if (rd_resp_valid) pop_chk("t3_data");
         cyc();
      end
      chk("t3_grant_order", 64'(gseq), 64'b0101);
      chk("t3_no_double_grant", 64'(both), 64'd0);
      chk("t3_drained", 64'(exp_q.size()), 64'd0);

      // Fill all entries, then clear the frame.
      for (int i = 0; i < N_ENTRY; i++) do_write(IW'(i), 32'h100 + i);
      smp();
      chk("t4_full_in_wr", 64'(frame_full), 64'd0);
      cyc();
      smp();
      chk("t4_full", 64'(frame_full), 64'd1);
      cyc();
      frame_clr = 1'b1;
      cyc();
      frame_clr = 1'b0;
      rd_idx = 4'd0; rd_valid = 1'b1;
      smp();
      chk("t4_full_clr", 64'(frame_full), 64'd0);
      chk("t4_stall_after_clr", 64'(rd_ready), 64'd0);
      for (int k = 0; k < 2; k++) begin
         cyc();
         smp();
         chk("t4_stall_after_clr", 64'(rd_ready), 64'd0);
      end
      cyc();
      rd_valid = 1'b0;

      // Out-of-range indices.
      do_write(4'd12, 32'h00000BAD);
      smp();
      chk("t5_wr_err", 64'(err_idx), 64'd1);
      chk("t5_wsel_zero", 64'(rf_wsel), 64'h000);
      cyc();
      smp();
      chk("t5_err_one_shot", 64'(err_idx), 64'd0);
      chk("t5_full_unchanged", 64'(frame_full), 64'd0);
      cyc();
      do_read(4'd15, 1'b1);
      smp();
      chk("t5_rd_err", 64'(err_idx), 64'd1);
      chk("t5_rsel_zero", 64'(rf_rsel), 64'h000);
      cyc();
      smp();
      chk("t5_valid", 64'(rd_resp_valid), 64'd1);
      chk("t5_rd_err_off", 64'(err_idx), 64'd0);
      pop_chk("t5_data");
      cyc();

      // Backpressured response interrupted by reset.
      do_write(4'd7, 32'hA5A55A5A);
      do_read(4'd7, 1'b0);
      cyc();
      for (int k = 0; k < 5; k++) begin
         smp();
         chk("t6_hold_valid", 64'(rd_resp_valid), 64'd1);
         chk("t6_hold_data", 64'(rd_resp_data), 64'hA5A55A5A);
         cyc();
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      exp_q.delete();
      smp();
      chk("t6_rst_valid", 64'(rd_resp_valid), 64'd0);
      chk("t6_rst_data", 64'(rd_resp_data), 64'd0);
      chk("t6_rst_full", 64'(frame_full), 64'd0);
      cyc();
      rd_idx = 4'd7; rd_valid = 1'b1; rd_resp_ready = 1'b1;
      smp();
      chk("t6_sb_cleared", 64'(rd_ready), 64'd0);
      cyc();
      rd_valid = 1'b0;
      smp();
      chk("t6_idle_no_resp", 64'(rd_resp_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
